// File: rtl/mips_multicycle_ctrl.sv
// Control sequencer for the MIPS32 multi-cycle datapath: one phase per clock,
// decodes opcode/funct, counts retired instructions and traps on bad encodings.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             sig_mem_read,
    output logic             sig_mem_write,
    output logic             sig_reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_retired;
    logic             w_pc_write;
    logic             w_pc_write_cond;
    logic             w_retire;
    logic             w_funct_ok;
    logic [2:0]       w_r_alu_op;

    // R-type funct decode; unknown funct falls back to ADD and steers to TRAP.
    always_comb begin
        w_funct_ok = 1'b1;
        w_r_alu_op = ALU_ADD;
        case (funct)
            6'b100100: w_r_alu_op = ALU_AND;
            6'b100101: w_r_alu_op = ALU_OR;
            6'b100000: w_r_alu_op = ALU_ADD;
            6'b100010: w_r_alu_op = ALU_SUB;
            6'b101010: w_r_alu_op = ALU_SLT;
            default:   w_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:     w_next = run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      w_next = S_EXECUTE;
                    OP_LW, OP_SW:  w_next = S_MEM_ADDR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_ADDI_EX;
                    default:       w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  w_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = S_MEM_WB;
            S_EXECUTE:   w_next = w_funct_ok ? S_R_WB : S_TRAP;
            S_ADDI_EX:   w_next = S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB,
            S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
            default:     w_next = S_TRAP;
        endcase
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        pc_source       = 2'b00;
        i_or_d          = 1'b0;
        ir_write        = 1'b0;
        sig_mem_read    = 1'b0;
        sig_mem_write   = 1'b0;
        sig_reg_write   = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 3'b000;
        case (r_state)
            S_FETCH: begin
                if (run) begin
                    sig_mem_read = 1'b1;
                    ir_write     = 1'b1;
                    alu_src_b    = 2'b01;
                    alu_op       = ALU_ADD;
                    w_pc_write   = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                i_or_d       = 1'b1;
                sig_mem_read = 1'b1;
            end
            S_MEM_WB: begin
                sig_reg_write = 1'b1;
                mem_to_reg    = 1'b1;
            end
            S_MEM_WRITE: begin
                i_or_d        = 1'b1;
                sig_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = w_r_alu_op;
            end
            S_R_WB: begin
                sig_reg_write = 1'b1;
                reg_dst       = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = ALU_SUB;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
            end
            S_ADDI_WB: sig_reg_write = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEM_WB, S_MEM_WRITE, S_R_WB,
            S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
            default: w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc_en   = w_pc_write | (w_pc_write_cond & zero);
    assign state   = r_state;
    assign illegal = (r_state == S_TRAP);
    assign retired = r_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed and random instruction streams
// compared against a per-instruction phase model, with a narrow counter to see wrap.
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          zero;
    logic          pc_en;
    logic [1:0]    pc_source;
    logic          i_or_d;
    logic          ir_write;
    logic          sig_mem_read;
    logic          sig_mem_write;
    logic          sig_reg_write;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          alu_src_a;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic          illegal;
    logic [CW-1:0] retired;

    typedef struct packed {
        logic       pc_en;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       a;
        logic [1:0] b;
        logic [2:0] alu;
        logic       illegal;
    } ctrl_t;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_retired = '0;
    int            path_q[$];

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d), .ir_write(ir_write),
        .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .sig_reg_write(sig_reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected control word for one phase, straight from the phase table.
    function automatic ctrl_t spec_ctrl(int st, logic r, logic [5:0] fn, logic z);
        ctrl_t c;
        c = '0;
        case (st)
            0:  if (r) begin c.mem_read = 1; c.ir_write = 1; c.b = 2'b01; c.alu = 3'b010; c.pc_en = 1; end
            1:  begin c.b = 2'b11; c.alu = 3'b010; end
            2:  begin c.a = 1; c.b = 2'b10; c.alu = 3'b010; end
            3:  begin c.i_or_d = 1; c.mem_read = 1; end
            4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
            5:  begin c.i_or_d = 1; c.mem_write = 1; end
            6:  begin
                    c.a = 1;
                    if      (fn == 6'b100100) c.alu = 3'b000;
                    else if (fn == 6'b100101) c.alu = 3'b001;
                    else if (fn == 6'b100010) c.alu = 3'b110;
                    else if (fn == 6'b101010) c.alu = 3'b111;
                    else                      c.alu = 3'b010;
                end
            7:  begin c.reg_write = 1; c.reg_dst = 1; end
            8:  begin c.a = 1; c.alu = 3'b110; c.pc_source = 2'b01; c.pc_en = z; end
            9:  begin c.pc_en = 1; c.pc_source = 2'b10; end
            10: begin c.a = 1; c.b = 2'b10; c.alu = 3'b010; end
            11: c.reg_write = 1;
            12: c.illegal = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic bit funct_legal(logic [5:0] fn);
        return fn inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
    endfunction

    // Phase sequence an instruction walks through, by instruction class.
    task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
        path_q = {0, 1};
        case (op)
            6'b000000: if (funct_legal(fn)) path_q = {path_q, 6, 7}; else path_q = {path_q, 6, 12};
            6'b100011: path_q = {path_q, 2, 3, 4};
            6'b101011: path_q = {path_q, 2, 5};
            6'b000100: path_q.push_back(8);
            6'b000010: path_q.push_back(9);
            6'b001000: path_q = {path_q, 10, 11};
            default:   path_q.push_back(12);
        endcase
    endtask

    task automatic check_cycle(input int st);
        ctrl_t obs;
        ctrl_t exp;
        obs = '{pc_en, pc_source, i_or_d, ir_write, sig_mem_read, sig_mem_write,
                sig_reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal};
        exp = spec_ctrl(st, run, funct, zero);
        check($sformatf("state@%0d", st), 32'(state), 32'(st));
        check($sformatf("ctrl@%0d", st), 32'(obs), 32'(exp));
        check($sformatf("retired@%0d", st), 32'(retired), 32'(exp_retired));
    endtask

    // Walks one instruction from FETCH; steps<0 means the full path.
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic zb, input int steps);
        int n;
        build_path(op, fn);
        n = (steps < 0) ? path_q.size() : steps;
        for (int k = 0; k < n; k++) begin
            run    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode = op;
            funct  = fn;
            zero   = (path_q[k] == 8) ? zb : 1'($urandom_range(0, 1));
            #1;
            check_cycle(path_q[k]);
            tick();
        end
        if (steps < 0 && path_q[path_q.size()-1] != 12) exp_retired = exp_retired + 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        tick();
        exp_retired = '0;
        tick();
        #1;
        check_cycle(0);
        rst = 1'b0;
    endtask

    task automatic trap_hold();
        for (int i = 0; i < 4; i++) begin
            run  = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            check_cycle(12);
            tick();
        end
        do_reset();
        check("illegal_after_rst", 32'(illegal), 32'd0);
    endtask

    logic [5:0] ops_tab [6];
    logic [5:0] fns_tab [5];

    initial begin
        ops_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        fns_tab = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
        rst = 1'b1; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0;

        do_reset();
        for (int i = 0; i < 3; i++) begin
            run = 1'b0;
            #1;
            check_cycle(0);
            tick();
        end

        // Reset landing in MEM_READ must abort the load without a writeback.
        do_instr(6'b100011, 6'b000000, 1'b0, 3);
        rst = 1'b1; run = 1'b0;
        #1;
        check_cycle(3);
        tick();
        rst = 1'b0;
        #1;
        check_cycle(0);

        do_instr(6'b000000, 6'b100000, 1'b0, -1);
        do_instr(6'b100011, 6'b000000, 1'b0, -1);
        do_instr(6'b101011, 6'b000000, 1'b0, -1);
        do_instr(6'b000100, 6'b000000, 1'b1, -1);
        do_instr(6'b000100, 6'b000000, 1'b0, -1);
        do_instr(6'b000010, 6'b000000, 1'b0, -1);
        do_instr(6'b001000, 6'b000000, 1'b0, -1);
        for (int i = 0; i < 5; i++) do_instr(6'b000000, fns_tab[i], 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            do_instr(ops_tab[$urandom_range(0, 5)], fns_tab[$urandom_range(0, 4)],
                     1'($urandom_range(0, 1)), -1);
        end

        do_instr(6'b111111, 6'b000000, 1'b0, -1);
        trap_hold();
        do_instr(6'b000000, 6'b000111, 1'b0, -1);
        trap_hold();

        for (int i = 0; i < 20; i++) begin
            do_instr(ops_tab[$urandom_range(0, 5)], fns_tab[$urandom_range(0, 4)],
                     1'($urandom_range(0, 1)), -1);
        end
        run = 1'b0;
        #1;
        check_cycle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
